// File: rtl/debounce_press_counter_pkg.sv
// Shared definitions for the press debouncer: state encoding, timer width
// and default parameter values, reusable by the display stage and benches.
package debounce_press_counter_pkg;

  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_CNT_WIDTH     = 8;
  localparam int unsigned TIMER_WIDTH       = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

endpackage

// File: rtl/debounce_press_counter_wrap_counter.sv
// Wrapping press counter with a sticky overflow flag.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : count one accepted press this cycle
//   clear      : synchronous clear of count and overflow (beats inc)
//   count      : presses modulo 2^CNT_WIDTH
//   overflow   : set on the edge count wraps to zero, held until clear/reset
module wrap_counter #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Increment / wrap / clear; clear has priority over a simultaneous inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      count <= count + CNT_WIDTH'(1);
      if (count == CNT_MAX) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_press_counter.sv
// Press/release debouncer for an already-synchronized button level.
// Emits a one-cycle press_pulse per accepted press and counts presses.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   input_sync  : synchronized input level
//   clear       : synchronous clear of count and overflow
//   press_pulse : one-cycle strobe per accepted press
//   held        : high while a debounced press is active (HELD/RELEASE)
//   count       : accepted presses modulo 2^CNT_WIDTH
//   overflow    : sticky wrap flag
module debounce_press_counter
  import debounce_press_counter_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_sync,
  input  logic                 clear,
  output logic                 press_pulse,
  output logic                 held,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(STABLE_CYCLES - 1);

  state_t                 state;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   timer_done_c;
  logic                   accept_c;

  assign timer_done_c = (timer == TIMER_LAST);
  // Press accepted on the STABLE_CYCLES-th consecutive high sample.
  assign accept_c     = (state == DEBOUNCE) && input_sync && timer_done_c;

  // Debounce FSM with timer; held tracks the state registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      press_pulse <= 1'b0;
      held        <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (input_sync) begin
            state <= DEBOUNCE;
            timer <= TIMER_WIDTH'(1);
          end
        end
        DEBOUNCE: begin
          if (!input_sync) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer_done_c) begin
            state       <= HELD;
            timer       <= '0;
            press_pulse <= 1'b1;
            held        <= 1'b1;
          end else begin
            timer <= timer + TIMER_WIDTH'(1);
          end
        end
        HELD: begin
          if (!input_sync) begin
            state <= RELEASE;
            timer <= TIMER_WIDTH'(1);
          end
        end
        RELEASE: begin
          // A high sample here is a release glitch: back to HELD, no pulse.
          if (input_sync) begin
            state <= HELD;
            timer <= '0;
          end else if (timer_done_c) begin
            state <= IDLE;
            timer <= '0;
            held  <= 1'b0;
          end else begin
            timer <= timer + TIMER_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

  wrap_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_wrap_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (accept_c),
    .clear    (clear),
    .count    (count),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_debounce_press_counter.sv
// Directed bench: table of per-edge vectors for the 8-bit instance plus
// hand-written reset and overflow sequences (overflow on a 4-bit instance).
module tb_debounce_press_counter;

  logic       clk;
  logic       rst_n;
  logic       in_a, clr_a;
  logic       in_b, clr_b;
  logic       pulse_a, held_a, ovf_a;
  logic [7:0] cnt_a;
  logic       pulse_b, held_b, ovf_b;
  logic [3:0] cnt_b;

  int n_total;
  int n_pass;

  typedef struct {
    logic       in;
    logic       clr;
    logic       pulse;
    logic       held;
    logic [7:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  debounce_press_counter #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) dut_a (
    .clk (clk), .rst_n (rst_n), .input_sync (in_a), .clear (clr_a),
    .press_pulse (pulse_a), .held (held_a), .count (cnt_a), .overflow (ovf_a)
  );

  debounce_press_counter #(.STABLE_CYCLES(4), .CNT_WIDTH(4)) dut_b (
    .clk (clk), .rst_n (rst_n), .input_sync (in_b), .clear (clr_b),
    .press_pulse (pulse_b), .held (held_b), .count (cnt_b), .overflow (ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #30 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic i, input logic c, input logic p, input logic h,
                     input logic [7:0] n, input logic o);
    vec_t v;
    v.in = i; v.clr = c; v.pulse = p; v.held = h; v.cnt = n; v.ovf = o;
    vecs.push_back(v);
  endtask

  // Drive dut_a inputs, then sample 1 ns after the next rising edge.
  task automatic step_a(input logic i, input logic c);
    in_a  = i;
    clr_a = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic i);
    in_b = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    in_a = 1'b0; clr_a = 1'b0;
    in_b = 1'b0; clr_b = 1'b0;

    // Clean press: 10 high edges, then 10 low edges.
    for (int k = 1; k <= 10; k++) add(1, 0, k == 4, k >= 4, (k >= 4) ? 8'd1 : 8'd0, 0);
    for (int k = 1; k <= 10; k++) add(0, 0, 0, k < 4, 8'd1, 0);
    // Bounce 1,1,0,1,1,1,1: pulse on the 7th edge.
    add(1, 0, 0, 0, 8'd1, 0);
    add(1, 0, 0, 0, 8'd1, 0);
    add(0, 0, 0, 0, 8'd1, 0);
    add(1, 0, 0, 0, 8'd1, 0);
    add(1, 0, 0, 0, 8'd1, 0);
    add(1, 0, 0, 0, 8'd1, 0);
    add(1, 0, 1, 1, 8'd2, 0);
    // Release glitch 0,0,1,0,0,0,0 while HELD.
    add(0, 0, 0, 1, 8'd2, 0);
    add(0, 0, 0, 1, 8'd2, 0);
    add(1, 0, 0, 1, 8'd2, 0);
    add(0, 0, 0, 1, 8'd2, 0);
    add(0, 0, 0, 1, 8'd2, 0);
    add(0, 0, 0, 1, 8'd2, 0);
    add(0, 0, 0, 0, 8'd2, 0);
    // Clear coincident with press acceptance: count 0, pulse still fires.
    add(1, 0, 0, 0, 8'd2, 0);
    add(1, 0, 0, 0, 8'd2, 0);
    add(1, 0, 0, 0, 8'd2, 0);
    add(1, 1, 1, 1, 8'd0, 0);
    add(1, 0, 0, 1, 8'd0, 0);
    add(0, 0, 0, 1, 8'd0, 0);
    add(0, 0, 0, 1, 8'd0, 0);
    add(0, 0, 0, 1, 8'd0, 0);
    add(0, 0, 0, 0, 8'd0, 0);
    // Next press counts from zero.
    add(1, 0, 0, 0, 8'd0, 0);
    add(1, 0, 0, 0, 8'd0, 0);
    add(1, 0, 0, 0, 8'd0, 0);
    add(1, 0, 1, 1, 8'd1, 0);
    // Clear alone while HELD: state untouched, count cleared.
    add(1, 1, 0, 1, 8'd0, 0);
    add(0, 0, 0, 1, 8'd0, 0);
    add(0, 0, 0, 1, 8'd0, 0);
    add(0, 0, 0, 1, 8'd0, 0);
    add(0, 0, 0, 0, 8'd0, 0);

    // Reset state while rst_n is low.
    #5;
    chk("reset_pulse", 32'(pulse_a), 32'd0);
    chk("reset_held",  32'(held_a),  32'd0);
    chk("reset_count", 32'(cnt_a),   32'd0);
    chk("reset_ovf",   32'(ovf_a),   32'd0);
    #40 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step_a(vecs[i].in, vecs[i].clr);
      chk($sformatf("vec%0d_pulse", i), 32'(pulse_a), 32'(vecs[i].pulse));
      chk($sformatf("vec%0d_held",  i), 32'(held_a),  32'(vecs[i].held));
      chk($sformatf("vec%0d_count", i), 32'(cnt_a),   32'(vecs[i].cnt));
      chk($sformatf("vec%0d_ovf",   i), 32'(ovf_a),   32'(vecs[i].ovf));
    end

    // Mid-cycle reset while HELD with a pulse and a nonzero count.
    for (int k = 0; k < 4; k++) step_a(1'b1, 1'b0);
    chk("pre_rst_pulse", 32'(pulse_a), 32'd1);
    chk("pre_rst_count", 32'(cnt_a),   32'd1);
    #10 rst_n = 1'b0;
    #1;
    chk("async_rst_pulse", 32'(pulse_a), 32'd0);
    chk("async_rst_held",  32'(held_a),  32'd0);
    chk("async_rst_count", 32'(cnt_a),   32'd0);
    #10 rst_n = 1'b1;
    // input_sync still high: must re-debounce, pulse on the 4th edge.
    for (int k = 1; k <= 4; k++) begin
      step_a(1'b1, 1'b0);
      chk($sformatf("post_rst_pulse_e%0d", k), 32'(pulse_a), 32'(k == 4));
    end
    chk("post_rst_count", 32'(cnt_a), 32'd1);
    // Permanently high: no further presses counted.
    for (int k = 0; k < 6; k++) step_a(1'b1, 1'b0);
    chk("perm_high_count", 32'(cnt_a),   32'd1);
    chk("perm_high_pulse", 32'(pulse_a), 32'd0);
    in_a = 1'b0;

    // Overflow on the 4-bit instance: 17 clean presses.
    for (int p = 1; p <= 17; p++) begin
      for (int k = 0; k < 4; k++) step_b(1'b1);
      chk($sformatf("ovf_p%0d_pulse", p), 32'(pulse_b), 32'd1);
      chk($sformatf("ovf_p%0d_count", p), 32'(cnt_b),   32'(p % 16));
      chk($sformatf("ovf_p%0d_ovf",   p), 32'(ovf_b),   32'(p >= 16));
      for (int k = 0; k < 4; k++) step_b(1'b0);
    end
    chk("ovf_sticky", 32'(ovf_b), 32'd1);
    clr_b = 1'b1;
    step_b(1'b0);
    clr_b = 1'b0;
    chk("ovf_clear_count", 32'(cnt_b), 32'd0);
    chk("ovf_clear_ovf",   32'(ovf_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debounce_press_counter.md
Name: debounce_press_counter

Overview:
- Downstream consumer of the synchronized input from check_sync.
- Filters `input_sync` with a press/release debounce FSM.
- Emits a one-cycle `press_pulse` per accepted press and keeps a wrapping press count with a sticky overflow flag.
- Feeds the lab display/LED stage.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples needed to accept a press or a release. Legal range is 2..255.
- CNT_WIDTH, 8: width of the press counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- input_sync  input  1  already-synchronized level from check_sync.
- clear  input  1  synchronous clear of count and overflow.
- press_pulse  output  1  one-cycle strobe per accepted press.
- held  output  1  high while a debounced press is active.
- count  output  CNT_WIDTH  number of accepted presses, modulo 2^CNT_WIDTH.
- overflow  output  1  sticky; set when count wraps.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset: all outputs are registered. While rst_n=0: state=IDLE, timer=0, press_pulse=0, held=0, count=0, overflow=0. Deassertion takes effect at the next clk edge.
- Internal timer: 8 bits wide.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE. All transitions occur on a clk rising edge.
- IDLE:
  - input_sync=1 -> DEBOUNCE, timer=1.
  - Otherwise stay.
- DEBOUNCE:
  - input_sync=0 -> IDLE, timer=0. A single low sample aborts the press.
  - input_sync=1 and timer==STABLE_CYCLES-1 -> HELD, timer=0, press_pulse=1, count increments.
  - Otherwise timer+1.
- HELD:
  - input_sync=0 -> RELEASE, timer=1.
  - Otherwise stay.
- RELEASE:
  - input_sync=1 -> HELD, timer=0. The glitch is absorbed; no new pulse.
  - input_sync=0 and timer==STABLE_CYCLES-1 -> IDLE, timer=0.
  - Otherwise timer+1.
- Latency: press_pulse rises on the edge that samples the STABLE_CYCLES-th consecutive high input_sync. It falls on the following edge. It is never high for two consecutive cycles.
- held: 1 in HELD and RELEASE; 0 in IDLE and DEBOUNCE. It is registered with the state, so held rises on the same edge as press_pulse.
- count:
  - Increments by 1 per accepted press.
  - Wraps from 2^CNT_WIDTH-1 to 0; overflow is set to 1 on that same edge.
  - overflow stays 1 until clear or reset.
- clear:
  - Sampled synchronously. Next edge: count=0, overflow=0.
  - clear wins over a simultaneous increment: count=0, not 1.
  - clear does not affect FSM state or press_pulse.
- Reset mid-press: any state returns to IDLE immediately. A press in progress is lost and must re-debounce from its first high sample.
- input_sync held permanently high: exactly one press counted.

Decomposition:
- Shared include file: state encoding localparams (IDLE=2'd0, DEBOUNCE=2'd1, HELD=2'd2, RELEASE=2'd3) and the default STABLE_CYCLES/CNT_WIDTH constants, for reuse by the display stage and benches.
- One sub-module, `wrap_counter`:
  - Ports: clk, rst_n, inc, clear, count, overflow.
  - Parameterized by CNT_WIDTH.
  - Implements the increment, wrap, sticky-overflow and clear-priority rules.
- The FSM and timer stay in the top module.

Test Plan (clk period 60 ns; STABLE_CYCLES=4, CNT_WIDTH=8 unless noted):
1. Reset: rst_n=0 asserted mid-cycle, with input_sync=1 -> all outputs 0 immediately. After release, the first press_pulse arrives on the 4th edge sampling input_sync=1.
2. Clean press: input_sync high for 10 edges, then low for 10 edges -> press_pulse is high for exactly 1 cycle, on the 4th high edge. count=1. held is 1 from that edge until the 4th low edge.
3. Bounce: input_sync pattern 1,1,0,1,1,1,1 (one sample per edge) -> no pulse at edges 1-3. press_pulse on edge 7. count=1.
4. Release glitch: while HELD, input_sync pattern 0,0,1,0,0,0,0 -> held stays 1 throughout, then drops on the 4th consecutive low edge. No second pulse; count unchanged.
5. Overflow (CNT_WIDTH=4): 16 clean presses -> count goes 15 then 0, and overflow=1 on the 16th press edge. A 17th press gives count=1 with overflow still 1.
6. Clear collision: assert clear on the same edge as press acceptance -> count=0, overflow=0, press_pulse=1. The next press gives count=1.
